// File: rtl/ran_checker.sv
// Receive-side checker for the 5-bit pseudo-random word stream: locks onto the
// sequence, predicts each next word, and flags/counts mispredictions while locked.
module ran_checker #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [4:0]       in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [4:0]       expected,
  output logic [1:0]       dbg_state
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [MW-1:0]    match_cnt, match_n, match_inc;
  logic [LW-1:0]    miss_cnt, miss_n, miss_inc;
  logic [4:0]       exp_n;
  logic             err_n;
  logic [ERR_W-1:0] cnt_n;
  logic             bump;

  function automatic logic [4:0] next_word(input logic [4:0] d);
    logic n4, n3, n2;
    n4 = d[4] ^ d[1];
    n3 = d[3] ^ d[0];
    n2 = d[2] ^ n4;
    return {n4, n3, n2, d[1] ^ n3, d[0] ^ n2};
  endfunction

  assign match_inc = match_cnt + MW'(1);
  assign miss_inc  = miss_cnt + LW'(1);

  always_comb begin
    state_n = state;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    exp_n   = expected;
    err_n   = 1'b0;
    bump    = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (in_data != 5'd0) begin
            exp_n   = next_word(in_data);
            match_n = '0;
            state_n = VERIFY;
          end
        end
        VERIFY: begin
          if (in_data == expected) begin
            exp_n   = next_word(in_data);
            match_n = match_inc;
            if (int'(match_inc) == LOCK_CNT) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else if (in_data != 5'd0) begin
            exp_n   = next_word(in_data);
            match_n = '0;
          end else begin
            state_n = HUNT;
          end
        end
        LOCKED: begin
          if (in_data == expected) begin
            exp_n  = next_word(in_data);
            miss_n = '0;
          end else begin
            // Flywheel on our own prediction; a corrupted word must not reseed.
            err_n  = 1'b1;
            bump   = 1'b1;
            exp_n  = next_word(expected);
            miss_n = miss_inc;
            if (int'(miss_inc) == LOSS_CNT) state_n = HUNT;
          end
        end
        default: state_n = HUNT;
      endcase
    end
    cnt_n = err_count;
    if (clear)                         cnt_n = '0;
    else if (bump && err_count != '1)  cnt_n = err_count + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      match_cnt <= '0;
      miss_cnt  <= '0;
      expected  <= 5'd0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      expected  <= exp_n;
      err       <= err_n;
      err_count <= cnt_n;
    end
  end

  assign locked    = (state == LOCKED);
  assign dbg_state = state;

endmodule

// File: tb/tb_ran_checker.sv
// Scoreboard bench for ran_checker: two instances (default and ERR_W=2/LOSS_CNT=8)
// share one stimulus stream and are compared against a reference model each cycle.
module tb_ran_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, clear;
  logic [4:0] in_data;

  logic       locked_a, err_a, locked_b, err_b;
  logic [7:0] err_count_a;
  logic [1:0] err_count_b;
  logic [4:0] expected_a, expected_b;
  logic [1:0] dbg_state_a, dbg_state_b;

  ran_checker #(.LOCK_CNT(3), .LOSS_CNT(2), .ERR_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(locked_a), .err(err_a), .err_count(err_count_a), .expected(expected_a),
    .dbg_state(dbg_state_a)
  );

  ran_checker #(.LOCK_CNT(3), .LOSS_CNT(8), .ERR_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(locked_b), .err(err_b), .err_count(err_count_b), .expected(expected_b),
    .dbg_state(dbg_state_b)
  );

  int checks = 0;
  int errors = 0;
  logic [27:0] exp_q[$];

  // Reference model state, index 0 = instance a, 1 = instance b (0 HUNT, 1 VERIFY, 2 LOCKED).
  int         m_st[2], m_mc[2], m_mm[2], m_errc[2];
  logic [4:0] m_exp[2];
  logic       m_err[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [4:0] f_ref(input logic [4:0] d);
    return {d[4] ^ d[1], d[3] ^ d[0], d[2] ^ d[4] ^ d[1],
            d[1] ^ d[3] ^ d[0], d[0] ^ d[2] ^ d[4] ^ d[1]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_mc[i] = 0; m_mm[i] = 0; m_errc[i] = 0;
      m_exp[i] = 5'd0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input int lock_cnt, input int loss_cnt, input int maxc,
                            input logic v, input logic [4:0] d, input logic clr);
    logic bump;
    bump = 1'b0;
    m_err[i] = 1'b0;
    if (v) begin
      if (m_st[i] == 0) begin
        if (d != 0) begin m_exp[i] = f_ref(d); m_mc[i] = 0; m_st[i] = 1; end
      end else if (m_st[i] == 1) begin
        if (d == m_exp[i]) begin
          m_exp[i] = f_ref(d);
          m_mc[i]++;
          if (m_mc[i] == lock_cnt) begin m_st[i] = 2; m_mm[i] = 0; end
        end else if (d != 0) begin
          m_exp[i] = f_ref(d); m_mc[i] = 0;
        end else begin
          m_st[i] = 0;
        end
      end else begin
        if (d == m_exp[i]) begin
          m_exp[i] = f_ref(d); m_mm[i] = 0;
        end else begin
          m_err[i] = 1'b1; bump = 1'b1;
          m_exp[i] = f_ref(m_exp[i]);
          m_mm[i]++;
          if (m_mm[i] == loss_cnt) m_st[i] = 0;
        end
      end
    end
    if (clr) m_errc[i] = 0;
    else if (bump && m_errc[i] < maxc) m_errc[i]++;
  endtask

  function automatic logic [27:0] model_pack();
    logic [7:0] ca;
    logic [1:0] cb;
    ca = 8'(m_errc[0]);
    cb = 2'(m_errc[1]);
    return {2'(m_st[0]), m_st[0] == 2, m_err[0], ca, m_exp[0],
            2'(m_st[1]), m_st[1] == 2, m_err[1], cb, m_exp[1]};
  endfunction

  // Called just after a falling edge; drives one cycle and compares at the next falling edge.
  task automatic step(input logic v, input logic [4:0] d, input logic c, input string tag);
    logic [27:0] got, want;
    in_valid = v; in_data = d; clear = c;
    model_step(0, 3, 2, 255, v, d, c);
    model_step(1, 3, 8, 3, v, d, c);
    exp_q.push_back(model_pack());
    @(posedge clk);
    @(negedge clk);
    got  = {dbg_state_a, locked_a, err_a, err_count_a, expected_a,
            dbg_state_b, locked_b, err_b, err_count_b, expected_b};
    want = exp_q.pop_front();
    check_eq({tag, "_a"}, 32'(got[27:11]), 32'(want[27:11]));
    check_eq({tag, "_b"}, 32'(got[10:0]), 32'(want[10:0]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 5'd0; clear = 1'b0;
    exp_q.delete();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_out_a", {locked_a, err_a, err_count_a, expected_a}, 0);
    check_eq("rst_state_a", 32'(dbg_state_a), 0);
  endtask

  task automatic lock_on(input string tag);
    step(1'b1, 5'h1F, 1'b0, tag);
    step(1'b1, 5'h06, 1'b0, tag);
    step(1'b1, 5'h12, 1'b0, tag);
    step(1'b1, 5'h02, 1'b0, tag);
  endtask

  initial begin
    logic [4:0] seq[4];
    logic [4:0] gen, d;
    logic       v;
    seq[0] = 5'h1F; seq[1] = 5'h06; seq[2] = 5'h12; seq[3] = 5'h02;

    // Lock-on from the reference sequence.
    do_reset();
    lock_on("lock");
    check_eq("lock_locked", 32'(locked_a), 1);
    check_eq("lock_expected", 32'(expected_a), 32'h17);

    // Single error while locked, then recovery on the flywheel prediction.
    step(1'b1, 5'h00, 1'b0, "single_err");
    check_eq("single_err_pulse", 32'(err_a), 1);
    check_eq("single_err_count", 32'(err_count_a), 1);
    check_eq("single_err_locked", 32'(locked_a), 1);
    step(1'b1, 5'h0C, 1'b0, "recover");
    check_eq("recover_err", 32'(err_a), 0);
    check_eq("recover_expected", 32'(expected_a), 32'h0F);

    // Loss of lock after two consecutive mispredictions, then reseed.
    do_reset();
    lock_on("loss_lock");
    step(1'b1, 5'h05, 1'b0, "loss1");
    step(1'b1, 5'h05, 1'b0, "loss2");
    check_eq("loss_locked", 32'(locked_a), 0);
    check_eq("loss_count", 32'(err_count_a), 2);
    step(1'b1, 5'h05, 1'b0, "reseed");
    check_eq("reseed_state", 32'(dbg_state_a), 1);
    check_eq("reseed_err", 32'(err_a), 0);

    // Leading zeros in HUNT, then gaps between sequence words.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 5'h00, 1'b0, "zero_hunt");
    check_eq("zero_hunt_state", 32'(dbg_state_a), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i], 1'b0, "gap_word");
      if (i < 3) for (int j = 0; j < 5; j++) step(1'b0, 5'($urandom_range(0, 31)), 1'b0, "gap_idle");
    end
    check_eq("gap_locked", 32'(locked_a), 1);
    check_eq("gap_expected", 32'(expected_a), 32'h17);

    // Saturation on the narrow counter, then clear racing a mismatch.
    do_reset();
    lock_on("sat_lock");
    for (int i = 0; i < 5; i++) step(1'b1, 5'h00, 1'b0, "sat_miss");
    check_eq("sat_count", 32'(err_count_b), 3);
    check_eq("sat_locked", 32'(locked_b), 1);
    step(1'b1, 5'h00, 1'b1, "clear_race");
    check_eq("clear_race_err", 32'(err_b), 1);
    check_eq("clear_race_count", 32'(err_count_b), 0);

    // Asynchronous reset between edges while locked.
    do_reset();
    lock_on("async_lock");
    step(1'b1, 5'h00, 1'b0, "async_err");
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_a", {locked_a, err_a, err_count_a, expected_a}, 0);
    check_eq("async_rst_b", {locked_b, err_b, err_count_b, expected_b}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random stream: mostly the true sequence, with gaps, corruptions and clears.
    gen = 5'h1F;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 11) == 0) ? 5'($urandom_range(0, 31)) : gen;
      if (v) gen = f_ref(gen);
      step(v, d, ($urandom_range(0, 29) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
